tl_a_channel_arbiter_2to1: RTL and testbench
============================================

// Module: tl_a_channel_arbiter_2to1
// PURPOSE
//  2:1 TileLink-UL/UH arbiter: merges two client A channels onto one manager port and routes D back.
//  Sits between the two uncached client ports and the shared memory-side port in the FIFO-fixer stage.
//  Round-robin grant. Grant is locked while a beat is presented but not yet accepted, and for all beats of a burst.
//  Source is widened by 1 bit (MSB = input index); D responses are steered by that MSB.
// PARAMETERS
//  SRC_W       4   client source id width; manager side is SRC_W+1
//  ADDR_W      33  address width
//  DATA_W      64  beat width in bits (8 bytes per beat)
//  MAX_LGSIZE  6   largest legal a_bits_size (64 B = 8 beats); sets beat-counter width
// PORTS
//  clock                        in   1        single clock domain
//  reset                        in   1        asynchronous, active-low
//  auto_in_{0,1}_a_valid/ready  in/out  1     client A handshakes
//  auto_in_{0,1}_a_bits_{opcode,param,size,source,address,mask,data,corrupt}
//                               in  3,3,4,SRC_W,ADDR_W,DATA_W/8,DATA_W,1  client A payload
//  auto_in_{0,1}_d_valid/ready  out/in  1     client D handshakes
//  auto_in_{0,1}_d_bits_{opcode,param,size,source,sink,denied,data,corrupt}
//                               out 3,2,4,SRC_W,2,1,DATA_W,1  client D payload
//  auto_out_a_valid/ready       out/in  1     manager A handshake
//  auto_out_a_bits_*            out  as client A, except source is SRC_W+1  merged A payload
//  auto_out_d_valid/ready       in/out  1     manager D handshake
//  auto_out_d_bits_*            in   as client D, except source is SRC_W+1  shared D payload
// BEHAVIOUR
//  State regs: state {IDLE, HOLD, BURST}, sel (1b), last_grant (1b), beats_left (MAX_LGSIZE-2 bits).
//  Reset (async, active-low): state=IDLE, sel=0, last_grant=1, beats_left=0.
//   - All outputs are combinational from state and inputs.
//   - In reset with all inputs low, every valid/ready output is 0.
//  Beat count: opcode 0/1/2/3 (PutFull, PutPartial, Arith, Logic) with size>3 -> 1<<(size-3) beats.
//   - All other opcodes, or size<=3 -> 1 beat.
//  IDLE choice (combinational, zero latency):
//   - Only one client valid -> choose that client.
//   - Both valid -> choose !last_grant.
//   - Neither valid -> out_a_valid=0.
//  HOLD/BURST choice = sel.
//  Data path muxing:
//   - out_a_valid = chosen client valid; out_a_bits = chosen client bits, with out source = {chosen, in source}.
//   - in_i_a_ready = out_a_ready & (chosen==i); the unchosen client always sees ready=0.
//  fire = out_a_valid & out_a_ready.
//  IDLE:
//   - Valid & !ready -> HOLD, sel=choice. Grant frozen; the other client cannot steal it.
//   - Fire with beats==1 -> stay IDLE, last_grant=choice.
//   - Fire with beats>1 -> BURST, sel=choice, last_grant=choice, beats_left=beats-1.
//  HOLD:
//   - Fire with beats==1 -> IDLE, last_grant=sel.
//   - Fire with beats>1 -> BURST, beats_left=beats-1, last_grant=sel.
//   - No fire -> stay HOLD.
//  BURST:
//   - Each fire decrements beats_left.
//   - Fire while beats_left==1 -> IDLE. The next arbitration happens in that same following cycle.
//   - Selected client deasserting valid mid-burst -> out_a_valid=0; stay BURST; grant is not released.
//  D routing (stateless):
//   - i = out_d_bits_source[SRC_W].
//   - in_i_d_valid = out_d_valid & (i matches that client); the other client's d_valid=0.
//   - out_d_ready = in_i_d_ready.
//   - in_i_d_bits = out_d_bits with source[SRC_W-1:0]; all other fields pass through.
//  A and D are independent; simultaneous A fire and D fire need no interaction.
//  Reset asserted mid-burst: state -> IDLE immediately.
//   - Remaining beats are abandoned; recovery is the requester's duty.
//   - After release, client 0 wins a tie.
//  size > MAX_LGSIZE on a data opcode is illegal input; behaviour is undefined and is not tested.
// TESTING
//  1. Release reset; both clients valid with Get (opcode 4) every cycle, ready=1.
//     -> grants alternate 0,1,0,1; out source MSB alternates; first grant goes to client 0.
//  2. Client 0 PutFull size=6 (8 beats), client 1 Get pending, ready=1.
//     -> 8 consecutive client-0 beats; client 1 is granted on cycle 9; in_1_a_ready=0 throughout.
//  3. Client 1 valid alone with ready=0 for 3 cycles; client 0 raises valid on cycle 2.
//     -> HOLD keeps sel=1; client 1 fires when ready rises; client 0 fires next.
//  4. Mid-burst (after 3 of 4 beats, size=5), selected client drops valid 2 cycles.
//     -> out_a_valid=0 for 2 cycles; no grant change; remaining beat completes; then IDLE.
//  5. out_d_valid with source=5'h13, in_1_d_ready=0 then 1.
//     -> in_1_d_valid=1 with source 4'h3; in_0_d_valid=0; out_d_ready follows in_1_d_ready.
//  6. Assert reset after beat 2 of an 8-beat burst.
//     -> state IDLE; after release, Gets on both clients grant client 0 first.

Source files
------------

// File: rtl/tl_a_channel_arbiter_2to1.sv
// 2:1 TileLink-UL/UH arbiter: round-robin merge of two client A channels onto one
// manager port, with D responses steered back by the widened source MSB.
module tl_a_channel_arbiter_2to1 #(
  parameter int SRC_W      = 4,
  parameter int ADDR_W     = 33,
  parameter int DATA_W     = 64,
  parameter int MAX_LGSIZE = 6
) (
  input  logic                clock,
  input  logic                reset,
  // client 0 A
  input  logic                auto_in_0_a_valid,
  output logic                auto_in_0_a_ready,
  input  logic [2:0]          auto_in_0_a_bits_opcode,
  input  logic [2:0]          auto_in_0_a_bits_param,
  input  logic [3:0]          auto_in_0_a_bits_size,
  input  logic [SRC_W-1:0]    auto_in_0_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_0_a_bits_address,
  input  logic [DATA_W/8-1:0] auto_in_0_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_0_a_bits_data,
  input  logic                auto_in_0_a_bits_corrupt,
  // client 0 D
  output logic                auto_in_0_d_valid,
  input  logic                auto_in_0_d_ready,
  output logic [2:0]          auto_in_0_d_bits_opcode,
  output logic [1:0]          auto_in_0_d_bits_param,
  output logic [3:0]          auto_in_0_d_bits_size,
  output logic [SRC_W-1:0]    auto_in_0_d_bits_source,
  output logic [1:0]          auto_in_0_d_bits_sink,
  output logic                auto_in_0_d_bits_denied,
  output logic [DATA_W-1:0]   auto_in_0_d_bits_data,
  output logic                auto_in_0_d_bits_corrupt,
  // client 1 A
  input  logic                auto_in_1_a_valid,
  output logic                auto_in_1_a_ready,
  input  logic [2:0]          auto_in_1_a_bits_opcode,
  input  logic [2:0]          auto_in_1_a_bits_param,
  input  logic [3:0]          auto_in_1_a_bits_size,
  input  logic [SRC_W-1:0]    auto_in_1_a_bits_source,
  input  logic [ADDR_W-1:0]   auto_in_1_a_bits_address,
  input  logic [DATA_W/8-1:0] auto_in_1_a_bits_mask,
  input  logic [DATA_W-1:0]   auto_in_1_a_bits_data,
  input  logic                auto_in_1_a_bits_corrupt,
  // client 1 D
  output logic                auto_in_1_d_valid,
  input  logic                auto_in_1_d_ready,
  output logic [2:0]          auto_in_1_d_bits_opcode,
  output logic [1:0]          auto_in_1_d_bits_param,
  output logic [3:0]          auto_in_1_d_bits_size,
  output logic [SRC_W-1:0]    auto_in_1_d_bits_source,
  output logic [1:0]          auto_in_1_d_bits_sink,
  output logic                auto_in_1_d_bits_denied,
  output logic [DATA_W-1:0]   auto_in_1_d_bits_data,
  output logic                auto_in_1_d_bits_corrupt,
  // manager A
  output logic                auto_out_a_valid,
  input  logic                auto_out_a_ready,
  output logic [2:0]          auto_out_a_bits_opcode,
  output logic [2:0]          auto_out_a_bits_param,
  output logic [3:0]          auto_out_a_bits_size,
  output logic [SRC_W:0]      auto_out_a_bits_source,
  output logic [ADDR_W-1:0]   auto_out_a_bits_address,
  output logic [DATA_W/8-1:0] auto_out_a_bits_mask,
  output logic [DATA_W-1:0]   auto_out_a_bits_data,
  output logic                auto_out_a_bits_corrupt,
  // manager D
  input  logic                auto_out_d_valid,
  output logic                auto_out_d_ready,
  input  logic [2:0]          auto_out_d_bits_opcode,
  input  logic [1:0]          auto_out_d_bits_param,
  input  logic [3:0]          auto_out_d_bits_size,
  input  logic [SRC_W:0]      auto_out_d_bits_source,
  input  logic [1:0]          auto_out_d_bits_sink,
  input  logic                auto_out_d_bits_denied,
  input  logic [DATA_W-1:0]   auto_out_d_bits_data,
  input  logic                auto_out_d_bits_corrupt
);

  localparam int BC_W = MAX_LGSIZE - 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  // Data-carrying opcodes (PutFull/PutPartial/Arith/Logic) span 2^(size-3) beats.
  function automatic logic [BC_W-1:0] beat_count(input logic [2:0] op, input logic [3:0] size);
    logic [BC_W-1:0] n;
    n = {{(BC_W-1){1'b0}}, 1'b1};
    if ((op <= 3'd3) && (size > 4'd3)) begin
      n = n << (size - 4'd3);
    end else begin
      n = n;
    end
    return n;
  endfunction

  state_t          r_state;
  logic            r_sel;
  logic            r_last_grant;
  logic [BC_W-1:0] r_beats_left;

  state_t          w_state_nx;
  logic            w_sel_nx;
  logic            w_last_grant_nx;
  logic [BC_W-1:0] w_beats_left_nx;

  logic            w_choice;
  logic            w_fire;
  logic            w_d_idx;
  logic [BC_W-1:0] w_beats;
  logic [BC_W-1:0] w_one;

  assign w_one = {{(BC_W-1){1'b0}}, 1'b1};

  // Grant choice: zero-latency round-robin in IDLE, frozen on r_sel otherwise.
  always_comb begin
    w_choice = r_sel;
    if (r_state == ST_IDLE) begin
      if (auto_in_0_a_valid && !auto_in_1_a_valid) begin
        w_choice = 1'b0;
      end else if (!auto_in_0_a_valid && auto_in_1_a_valid) begin
        w_choice = 1'b1;
      end else if (auto_in_0_a_valid && auto_in_1_a_valid) begin
        w_choice = ~r_last_grant;
      end else begin
        w_choice = 1'b0;
      end
    end else begin
      w_choice = r_sel;
    end
  end

  assign auto_out_a_valid        = w_choice ? auto_in_1_a_valid        : auto_in_0_a_valid;
  assign auto_out_a_bits_opcode  = w_choice ? auto_in_1_a_bits_opcode  : auto_in_0_a_bits_opcode;
  assign auto_out_a_bits_param   = w_choice ? auto_in_1_a_bits_param   : auto_in_0_a_bits_param;
  assign auto_out_a_bits_size    = w_choice ? auto_in_1_a_bits_size    : auto_in_0_a_bits_size;
  assign auto_out_a_bits_source  = {w_choice, (w_choice ? auto_in_1_a_bits_source : auto_in_0_a_bits_source)};
  assign auto_out_a_bits_address = w_choice ? auto_in_1_a_bits_address : auto_in_0_a_bits_address;
  assign auto_out_a_bits_mask    = w_choice ? auto_in_1_a_bits_mask    : auto_in_0_a_bits_mask;
  assign auto_out_a_bits_data    = w_choice ? auto_in_1_a_bits_data    : auto_in_0_a_bits_data;
  assign auto_out_a_bits_corrupt = w_choice ? auto_in_1_a_bits_corrupt : auto_in_0_a_bits_corrupt;

  assign auto_in_0_a_ready = auto_out_a_ready & ~w_choice;
  assign auto_in_1_a_ready = auto_out_a_ready &  w_choice;

  assign w_fire  = auto_out_a_valid & auto_out_a_ready;
  assign w_beats = beat_count(auto_out_a_bits_opcode, auto_out_a_bits_size);

  // Next-state: HOLD pins an unaccepted beat, BURST pins the grant until the last beat.
  always_comb begin
    w_state_nx      = r_state;
    w_sel_nx        = r_sel;
    w_last_grant_nx = r_last_grant;
    w_beats_left_nx = r_beats_left;
    case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          w_last_grant_nx = w_choice;
          if (w_beats != w_one) begin
            w_state_nx      = ST_BURST;
            w_sel_nx        = w_choice;
            w_beats_left_nx = w_beats - w_one;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else if (auto_out_a_valid) begin
          w_state_nx = ST_HOLD;
          w_sel_nx   = w_choice;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (w_fire) begin
          w_last_grant_nx = r_sel;
          if (w_beats != w_one) begin
            w_state_nx      = ST_BURST;
            w_beats_left_nx = w_beats - w_one;
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else begin
          w_state_nx = ST_HOLD;
        end
      end
      ST_BURST: begin
        if (w_fire) begin
          w_beats_left_nx = r_beats_left - w_one;
          if (r_beats_left == w_one) begin
            w_state_nx = ST_IDLE;
          end else begin
            w_state_nx = ST_BURST;
          end
        end else begin
          w_state_nx = ST_BURST;
        end
      end
      default: begin
        w_state_nx      = ST_IDLE;
        w_beats_left_nx = {BC_W{1'b0}};
      end
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_sel        <= 1'b0;
      r_last_grant <= 1'b1;
      r_beats_left <= {BC_W{1'b0}};
    end else begin
      r_state      <= w_state_nx;
      r_sel        <= w_sel_nx;
      r_last_grant <= w_last_grant_nx;
      r_beats_left <= w_beats_left_nx;
    end
  end

  assign w_d_idx = auto_out_d_bits_source[SRC_W];

  assign auto_out_d_ready  = w_d_idx ? auto_in_1_d_ready : auto_in_0_d_ready;
  assign auto_in_0_d_valid = auto_out_d_valid & ~w_d_idx;
  assign auto_in_1_d_valid = auto_out_d_valid &  w_d_idx;

  assign auto_in_0_d_bits_opcode  = auto_out_d_bits_opcode;
  assign auto_in_0_d_bits_param   = auto_out_d_bits_param;
  assign auto_in_0_d_bits_size    = auto_out_d_bits_size;
  assign auto_in_0_d_bits_source  = auto_out_d_bits_source[SRC_W-1:0];
  assign auto_in_0_d_bits_sink    = auto_out_d_bits_sink;
  assign auto_in_0_d_bits_denied  = auto_out_d_bits_denied;
  assign auto_in_0_d_bits_data    = auto_out_d_bits_data;
  assign auto_in_0_d_bits_corrupt = auto_out_d_bits_corrupt;

  assign auto_in_1_d_bits_opcode  = auto_out_d_bits_opcode;
  assign auto_in_1_d_bits_param   = auto_out_d_bits_param;
  assign auto_in_1_d_bits_size    = auto_out_d_bits_size;
  assign auto_in_1_d_bits_source  = auto_out_d_bits_source[SRC_W-1:0];
  assign auto_in_1_d_bits_sink    = auto_out_d_bits_sink;
  assign auto_in_1_d_bits_denied  = auto_out_d_bits_denied;
  assign auto_in_1_d_bits_data    = auto_out_d_bits_data;
  assign auto_in_1_d_bits_corrupt = auto_out_d_bits_corrupt;

endmodule

// File: tb/tb_tl_a_channel_arbiter_2to1.sv
// Directed bench for the 2:1 TileLink A-channel arbiter: round-robin, bursts,
// HOLD locking, mid-burst stalls, D steering and reset mid-burst.
module tb_tl_a_channel_arbiter_2to1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        a0_valid, a0_ready, a0_corrupt;
  logic [2:0]  a0_opcode, a0_param;
  logic [3:0]  a0_size, a0_source;
  logic [32:0] a0_address;
  logic [7:0]  a0_mask;
  logic [63:0] a0_data;
  logic        a1_valid, a1_ready, a1_corrupt;
  logic [2:0]  a1_opcode, a1_param;
  logic [3:0]  a1_size, a1_source;
  logic [32:0] a1_address;
  logic [7:0]  a1_mask;
  logic [63:0] a1_data;

  logic        d0_valid, d0_ready, d0_denied, d0_corrupt;
  logic [2:0]  d0_opcode;
  logic [1:0]  d0_param, d0_sink;
  logic [3:0]  d0_size, d0_source;
  logic [63:0] d0_data;
  logic        d1_valid, d1_ready, d1_denied, d1_corrupt;
  logic [2:0]  d1_opcode;
  logic [1:0]  d1_param, d1_sink;
  logic [3:0]  d1_size, d1_source;
  logic [63:0] d1_data;

  logic        oa_valid, oa_ready, oa_corrupt;
  logic [2:0]  oa_opcode, oa_param;
  logic [3:0]  oa_size;
  logic [4:0]  oa_source;
  logic [32:0] oa_address;
  logic [7:0]  oa_mask;
  logic [63:0] oa_data;

  logic        od_valid, od_ready, od_denied, od_corrupt;
  logic [2:0]  od_opcode;
  logic [1:0]  od_param, od_sink;
  logic [3:0]  od_size;
  logic [4:0]  od_source;
  logic [63:0] od_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  tl_a_channel_arbiter_2to1 dut (
    .clock(clock), .reset(reset),
    .auto_in_0_a_valid(a0_valid), .auto_in_0_a_ready(a0_ready),
    .auto_in_0_a_bits_opcode(a0_opcode), .auto_in_0_a_bits_param(a0_param),
    .auto_in_0_a_bits_size(a0_size), .auto_in_0_a_bits_source(a0_source),
    .auto_in_0_a_bits_address(a0_address), .auto_in_0_a_bits_mask(a0_mask),
    .auto_in_0_a_bits_data(a0_data), .auto_in_0_a_bits_corrupt(a0_corrupt),
    .auto_in_0_d_valid(d0_valid), .auto_in_0_d_ready(d0_ready),
    .auto_in_0_d_bits_opcode(d0_opcode), .auto_in_0_d_bits_param(d0_param),
    .auto_in_0_d_bits_size(d0_size), .auto_in_0_d_bits_source(d0_source),
    .auto_in_0_d_bits_sink(d0_sink), .auto_in_0_d_bits_denied(d0_denied),
    .auto_in_0_d_bits_data(d0_data), .auto_in_0_d_bits_corrupt(d0_corrupt),
    .auto_in_1_a_valid(a1_valid), .auto_in_1_a_ready(a1_ready),
    .auto_in_1_a_bits_opcode(a1_opcode), .auto_in_1_a_bits_param(a1_param),
    .auto_in_1_a_bits_size(a1_size), .auto_in_1_a_bits_source(a1_source),
    .auto_in_1_a_bits_address(a1_address), .auto_in_1_a_bits_mask(a1_mask),
    .auto_in_1_a_bits_data(a1_data), .auto_in_1_a_bits_corrupt(a1_corrupt),
    .auto_in_1_d_valid(d1_valid), .auto_in_1_d_ready(d1_ready),
    .auto_in_1_d_bits_opcode(d1_opcode), .auto_in_1_d_bits_param(d1_param),
    .auto_in_1_d_bits_size(d1_size), .auto_in_1_d_bits_source(d1_source),
    .auto_in_1_d_bits_sink(d1_sink), .auto_in_1_d_bits_denied(d1_denied),
    .auto_in_1_d_bits_data(d1_data), .auto_in_1_d_bits_corrupt(d1_corrupt),
    .auto_out_a_valid(oa_valid), .auto_out_a_ready(oa_ready),
    .auto_out_a_bits_opcode(oa_opcode), .auto_out_a_bits_param(oa_param),
    .auto_out_a_bits_size(oa_size), .auto_out_a_bits_source(oa_source),
    .auto_out_a_bits_address(oa_address), .auto_out_a_bits_mask(oa_mask),
    .auto_out_a_bits_data(oa_data), .auto_out_a_bits_corrupt(oa_corrupt),
    .auto_out_d_valid(od_valid), .auto_out_d_ready(od_ready),
    .auto_out_d_bits_opcode(od_opcode), .auto_out_d_bits_param(od_param),
    .auto_out_d_bits_size(od_size), .auto_out_d_bits_source(od_source),
    .auto_out_d_bits_sink(od_sink), .auto_out_d_bits_denied(od_denied),
    .auto_out_d_bits_data(od_data), .auto_out_d_bits_corrupt(od_corrupt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a0(input logic v, input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src);
    a0_valid = v; a0_opcode = op; a0_size = sz; a0_source = src;
  endtask

  task automatic set_a1(input logic v, input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src);
    a1_valid = v; a1_opcode = op; a1_size = sz; a1_source = src;
  endtask

  initial begin
    set_a0(1'b0, 3'd0, 4'd0, 4'h0); set_a1(1'b0, 3'd0, 4'd0, 4'h0);
    a0_param = 3'd0; a0_address = 33'h1_0000_0000; a0_mask = 8'hFF; a0_data = 64'hA0A0_A0A0_A0A0_A0A0; a0_corrupt = 1'b0;
    a1_param = 3'd0; a1_address = 33'h0_0000_1000; a1_mask = 8'h0F; a1_data = 64'hB1B1_B1B1_B1B1_B1B1; a1_corrupt = 1'b0;
    d0_ready = 1'b0; d1_ready = 1'b0; oa_ready = 1'b0;
    od_valid = 1'b0; od_opcode = 3'd0; od_param = 2'd0; od_size = 4'd0; od_source = 5'h00;
    od_sink = 2'd0; od_denied = 1'b0; od_data = 64'd0; od_corrupt = 1'b0;

    // Reset with all inputs low: every valid/ready output is 0.
    tick(); tick();
    check("rst_a0_ready", 64'(a0_ready), 64'd0);
    check("rst_a1_ready", 64'(a1_ready), 64'd0);
    check("rst_oa_valid", 64'(oa_valid), 64'd0);
    check("rst_d0_valid", 64'(d0_valid), 64'd0);
    check("rst_d1_valid", 64'(d1_valid), 64'd0);
    check("rst_od_ready", 64'(od_ready), 64'd0);
    reset = 1'b1;
    tick();

    // 1: both clients issue Gets every cycle; grants alternate starting at 0.
    set_a0(1'b1, 3'd4, 4'd3, 4'h1); set_a1(1'b1, 3'd4, 4'd3, 4'h2); oa_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic g;
      g = k[0];
      check("t1_valid", 64'(oa_valid), 64'd1);
      check("t1_source", 64'(oa_source), g ? 64'h12 : 64'h01);
      check("t1_rdy0", 64'(a0_ready), g ? 64'd0 : 64'd1);
      check("t1_rdy1", 64'(a1_ready), g ? 64'd1 : 64'd0);
      check("t1_data", oa_data, g ? 64'hB1B1_B1B1_B1B1_B1B1 : 64'hA0A0_A0A0_A0A0_A0A0);
      tick();
    end

    // 2: 8-beat PutFull from client 0 holds off client 1 until cycle 9.
    set_a0(1'b1, 3'd0, 4'd6, 4'h3); set_a1(1'b1, 3'd4, 4'd3, 4'h4);
    #1;
    for (int k = 0; k < 8; k++) begin
      check("t2_burst_src", 64'(oa_source), 64'h03);
      check("t2_burst_rdy1", 64'(a1_ready), 64'd0);
      check("t2_burst_rdy0", 64'(a0_ready), 64'd1);
      tick();
    end
    check("t2_c9_src", 64'(oa_source), 64'h14);
    check("t2_c9_rdy1", 64'(a1_ready), 64'd1);
    check("t2_c9_rdy0", 64'(a0_ready), 64'd0);
    tick();
    set_a0(1'b0, 3'd4, 4'd3, 4'h0); set_a1(1'b0, 3'd4, 4'd3, 4'h0);

    // 3: client 1 stalled in HOLD keeps the grant while client 0 waits.
    oa_ready = 1'b0;
    set_a1(1'b1, 3'd4, 4'd3, 4'h5);
    #1;
    check("t3_c1_valid", 64'(oa_valid), 64'd1);
    check("t3_c1_src", 64'(oa_source), 64'h15);
    check("t3_c1_rdy1", 64'(a1_ready), 64'd0);
    tick();
    set_a0(1'b1, 3'd4, 4'd3, 4'h6);
    #1;
    check("t3_c2_src", 64'(oa_source), 64'h15);
    check("t3_c2_rdy0", 64'(a0_ready), 64'd0);
    tick();
    check("t3_c3_src", 64'(oa_source), 64'h15);
    tick();
    oa_ready = 1'b1;
    #1;
    check("t3_c4_src", 64'(oa_source), 64'h15);
    check("t3_c4_rdy1", 64'(a1_ready), 64'd1);
    check("t3_c4_rdy0", 64'(a0_ready), 64'd0);
    tick();
    set_a1(1'b0, 3'd4, 4'd3, 4'h0);
    #1;
    check("t3_c5_src", 64'(oa_source), 64'h06);
    check("t3_c5_rdy0", 64'(a0_ready), 64'd1);
    tick();
    set_a0(1'b0, 3'd4, 4'd3, 4'h0);

    // 4: 4-beat burst stalls after 3 beats; grant is not released.
    set_a0(1'b1, 3'd0, 4'd5, 4'h7);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("t4_beat_src", 64'(oa_source), 64'h07);
      check("t4_beat_valid", 64'(oa_valid), 64'd1);
      tick();
    end
    a0_valid = 1'b0;
    set_a1(1'b1, 3'd4, 4'd3, 4'h8);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("t4_stall_valid", 64'(oa_valid), 64'd0);
      check("t4_stall_rdy1", 64'(a1_ready), 64'd0);
      tick();
    end
    a0_valid = 1'b1;
    #1;
    check("t4_last_src", 64'(oa_source), 64'h07);
    check("t4_last_rdy0", 64'(a0_ready), 64'd1);
    tick();
    a0_valid = 1'b0;
    #1;
    check("t4_idle_src", 64'(oa_source), 64'h18);
    check("t4_idle_rdy1", 64'(a1_ready), 64'd1);
    tick();
    set_a1(1'b0, 3'd4, 4'd3, 4'h0);

    // 5: D steering by source MSB.
    od_valid = 1'b1; od_source = 5'h13; od_opcode = 3'd1; od_sink = 2'd2;
    od_data = 64'hDEAD_BEEF_0123_4567; d1_ready = 1'b0; d0_ready = 1'b1;
    #1;
    check("t5_d1_valid", 64'(d1_valid), 64'd1);
    check("t5_d1_source", 64'(d1_source), 64'h3);
    check("t5_d0_valid", 64'(d0_valid), 64'd0);
    check("t5_od_ready0", 64'(od_ready), 64'd0);
    check("t5_d1_data", d1_data, 64'hDEAD_BEEF_0123_4567);
    check("t5_d1_sink", 64'(d1_sink), 64'd2);
    d1_ready = 1'b1; d0_ready = 1'b0;
    #1;
    check("t5_od_ready1", 64'(od_ready), 64'd1);
    od_source = 5'h05;
    #1;
    check("t5_c0_d0_valid", 64'(d0_valid), 64'd1);
    check("t5_c0_d1_valid", 64'(d1_valid), 64'd0);
    check("t5_c0_d0_source", 64'(d0_source), 64'h5);
    check("t5_c0_od_ready", 64'(od_ready), 64'd0);
    od_valid = 1'b0; d1_ready = 1'b0;
    tick();

    // 6: reset after beat 2 of an 8-beat burst returns to IDLE; client 0 wins the tie.
    set_a0(1'b1, 3'd0, 4'd6, 4'h9);
    #1;
    tick(); tick();
    set_a1(1'b1, 3'd4, 4'd3, 4'hA);
    #1;
    check("t6_burst_src", 64'(oa_source), 64'h09);
    reset = 1'b0;
    set_a0(1'b0, 3'd4, 4'd3, 4'h9);
    #1;
    check("t6_rst_valid", 64'(oa_valid), 64'd1);
    check("t6_rst_src", 64'(oa_source), 64'h1A);
    tick();
    check("t6_rst_hold_src", 64'(oa_source), 64'h1A);
    set_a0(1'b1, 3'd4, 4'd3, 4'h9);
    #1;
    check("t6_rst_tie_src", 64'(oa_source), 64'h09);
    reset = 1'b1;
    #1;
    check("t6_rel_first_src", 64'(oa_source), 64'h09);
    tick();
    check("t6_rel_second_src", 64'(oa_source), 64'h1A);
    tick();
    set_a0(1'b0, 3'd4, 4'd3, 4'h0); set_a1(1'b0, 3'd4, 4'd3, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
